// File: rtl/register_pipe.sv
// register_pipe: elastic valid/ready pipeline of STAGES registers, WIDTH bits each
//
// Parameters:
//   WIDTH   data bits per stage (>=1)
//   STAGES  number of register stages (1..15)
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active low
//   flush      drops all in-flight data on the next edge
//   in_valid   upstream word present on in_data
//   in_ready   pipe accepts in_data this cycle (combinational from out_ready)
//   in_data    input word
//   out_valid  last stage holds a word
//   out_ready  downstream accepts out_data this cycle
//   out_data   last-stage word
//   occupancy  number of stages holding valid data
// Build option:
//   REGISTER_PIPE_DATA_CLEAR_EN  when defined, reset, flush and emptying stages
//   zero the data registers so out_data reads 0 while out_valid is low.
module register_pipe #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [3:0]       occupancy
);
   logic [STAGES-1:0] v, a, ld, sv, v_nxt;
   logic [WIDTH-1:0]  d  [STAGES];
   logic [WIDTH-1:0]  sd [STAGES];
   logic              in_xfer;
   logic              acc;
   logic [3:0]        cnt;
   // a stage advances if the one after it advances or is empty
   always_comb begin
      a = '0;
      acc = out_ready;
      a[STAGES-1] = acc;
      for (int i = STAGES-2; i >= 0; i--) begin
         acc = acc | ~v[i+1];
         a[i] = acc;
      end
   end
   assign ld       = ~v | a;
   assign in_ready = ld[0] & ~flush;
   assign in_xfer  = in_valid & in_ready;
   // source of each stage: stage 0 takes the input transfer, others their predecessor
   always_comb begin
      sv[0] = in_xfer;
      sd[0] = in_data;
      for (int i = 1; i < STAGES; i++) begin
         sv[i] = v[i-1];
         sd[i] = d[i-1];
      end
   end
   assign v_nxt = (ld & sv) | (~ld & v);
   always_comb begin
      cnt = '0;
      for (int i = 0; i < STAGES; i++) cnt = cnt + {3'b000, v_nxt[i]};
   end
   always_ff @(posedge clk) begin
      if (!rst) begin
         v <= '0;
         occupancy <= '0;
      end else if (flush) begin
         v <= '0;
         occupancy <= '0;
      end else begin
         v <= v_nxt;
         occupancy <= cnt;
      end
   end
`ifdef REGISTER_PIPE_DATA_CLEAR_EN
   always_ff @(posedge clk) begin
      for (int i = 0; i < STAGES; i++) begin
         if (!rst || flush) d[i] <= '0;
         else if (ld[i]) d[i] <= sv[i] ? sd[i] : '0;
      end
   end
`else
   // no reset on data; an emptying stage keeps its stale word
   always_ff @(posedge clk) begin
      for (int i = 0; i < STAGES; i++) begin
         if (ld[i] && sv[i]) d[i] <= sd[i];
      end
   end
`endif
   assign out_valid = v[STAGES-1];
   assign out_data  = d[STAGES-1];
endmodule

// File: tb/tb_register_pipe.sv
// tb_register_pipe: scoreboard bench for register_pipe (WIDTH=32, STAGES=3)
module tb_register_pipe;
   localparam int W = 32;
   localparam int S = 3;
   logic          clk = 0;
   logic          rst = 0;
   logic          flush = 0;
   logic          in_valid = 0;
   logic          in_ready;
   logic [W-1:0]  in_data = '0;
   logic          out_valid;
   logic          out_ready = 0;
   logic [W-1:0]  out_data;
   logic [3:0]    occupancy;
   int            n_tests = 0;
   int            n_fail = 0;
   bit            mon_en = 0;
   logic [W-1:0]  q [$];
   register_pipe #(.WIDTH(W), .STAGES(S)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .occupancy(occupancy)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   // scoreboard: check current state, then apply this cycle's transfers to the model
   always @(negedge clk) begin
      if (mon_en) begin
         logic exp_rdy;
         exp_rdy = !flush && (q.size() < S || out_ready);
         chk("mon_occ", {28'b0, occupancy}, 32'(q.size()));
         chk("mon_in_ready", {31'b0, in_ready}, {31'b0, exp_rdy});
         if (q.size() == 0) chk("mon_ov_empty", {31'b0, out_valid}, 32'd0);
         if (out_valid && q.size() > 0) chk("mon_data", out_data, q[0]);
`ifdef REGISTER_PIPE_DATA_CLEAR_EN
         if (!out_valid) chk("mon_data_zero", out_data, 32'd0);
`endif
         if (!rst) q.delete();
         else begin
            if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
            if (flush) q.delete();
            else if (in_valid && exp_rdy) q.push_back(in_data);
         end
      end
   end
   initial begin
      int acc;
      // reset with in_valid asserted
      rst = 0; in_valid = 1; in_data = 32'hdead; out_ready = 0;
      step(); step();
      rst = 1; in_valid = 0;
      #1;
      chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
      chk("rst_occ", {28'b0, occupancy}, 32'd0);
      chk("rst_ov", {31'b0, out_valid}, 32'd0);
`ifdef REGISTER_PIPE_DATA_CLEAR_EN
      chk("rst_data", out_data, 32'd0);
`endif
      mon_en = 1;
      // streaming: word k accepted at edge k-1, visible after edge k+1
      out_ready = 1;
      for (int c = 0; c <= 10; c++) begin
         in_valid = (c < 8);
         in_data = 32'(c + 1);
         step();
         chk("stream_ov", {31'b0, out_valid}, {31'b0, (c >= 2 && c <= 9)});
         if (c >= 2 && c <= 9) chk("stream_data", out_data, 32'(c - 1));
      end
      // backpressure fill
      in_valid = 0; out_ready = 0; acc = 0;
      for (int k = 0; k < 5; k++) begin
         in_valid = 1;
         in_data = 32'(acc + 1);
         #1;
         if (in_ready) acc++;
         step();
      end
      in_valid = 0;
      #1;
      chk("bp_accepted", 32'(acc), 32'd3);
      chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
      chk("bp_occ", {28'b0, occupancy}, 32'd3);
      out_ready = 1;
      #1;
      for (int k = 0; k < 3; k++) begin
         chk("bp_ov", {31'b0, out_valid}, 32'd1);
         chk("bp_data", out_data, 32'(k + 1));
         step();
      end
      chk("bp_drained", {31'b0, out_valid}, 32'd0);
      // bubble collapse
      out_ready = 0;
      in_valid = 1; in_data = 32'h10; step();
      in_valid = 0; step();
      in_valid = 1; in_data = 32'h20; step();
      in_valid = 0; step();
      chk("bub_occ", {28'b0, occupancy}, 32'd2);
      out_ready = 1;
      #1;
      chk("bub_ov0", {31'b0, out_valid}, 32'd1);
      chk("bub_d0", out_data, 32'h10);
      step();
      chk("bub_ov1", {31'b0, out_valid}, 32'd1);
      chk("bub_d1", out_data, 32'h20);
      step();
      chk("bub_empty", {31'b0, out_valid}, 32'd0);
      // flush mid-stream
      out_ready = 0;
      for (int k = 0; k < 3; k++) begin
         in_valid = 1; in_data = 32'h31 + 32'(k); step();
      end
      chk("fl_occ_full", {28'b0, occupancy}, 32'd3);
      out_ready = 1; in_valid = 1; in_data = 32'h40; flush = 1;
      #1;
      chk("fl_in_ready", {31'b0, in_ready}, 32'd0);
      chk("fl_ov", {31'b0, out_valid}, 32'd1);
      chk("fl_data", out_data, 32'h31);
      step();
      flush = 0;
      #1;
      chk("fl_occ", {28'b0, occupancy}, 32'd0);
      chk("fl_ov_after", {31'b0, out_valid}, 32'd0);
      chk("fl_in_ready_after", {31'b0, in_ready}, 32'd1);
      step();
      in_valid = 0;
      step(); step();
      chk("fl_alone_ov", {31'b0, out_valid}, 32'd1);
      chk("fl_alone_data", out_data, 32'h40);
      step();
      chk("fl_alone_empty", {31'b0, out_valid}, 32'd0);
      // random stress
      for (int c = 0; c < 10000; c++) begin
         in_valid = ($urandom_range(99) < 70);
         out_ready = ($urandom_range(99) < 60);
         flush = ($urandom_range(99) < 2);
         rst = !($urandom_range(999) < 2);
         in_data = $urandom;
         step();
      end
      rst = 1; flush = 0; in_valid = 0; out_ready = 1;
      repeat (5) step();
      chk("final_occ", {28'b0, occupancy}, 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
